// File: rtl/shifter_pkg.sv
// Shared types and constants for the shift-register word capture path.
// SHIFT_CAPTURE_PARITY_EN adds an even-parity bit to every captured entry.
package shifter_pkg;

  localparam int unsigned WORD_BITS_DEF  = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam logic MODE_TO_Q3 = 1'b0;
  localparam logic MODE_TO_Q0 = 1'b1;

  // Entry layout, MSB first: {dir, data[, par]}.
  function automatic int unsigned entry_width(int unsigned data_bits);
`ifdef SHIFT_CAPTURE_PARITY_EN
    return data_bits + 2;
`else
    return data_bits + 1;
`endif
  endfunction

  typedef struct packed {
    logic                     dir;
    logic [WORD_BITS_DEF-1:0] data;
`ifdef SHIFT_CAPTURE_PARITY_EN
    logic                     par;
`endif
  } cap_entry_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with push/pop/full/empty/level; pointers carry one extra wrap bit.
// Head entry is read directly from storage, so it holds steady until popped.
module word_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW:0]   wptr, rptr;
  logic             do_push, do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AddrW] != rptr[AddrW]) && (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AddrW-1:0]];

  // A pop frees the head slot on the same edge, so a push into a full FIFO still fits.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AddrW-1:0]] <= wdata;
        wptr                 <= wptr + (AddrW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AddrW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/shift_word_capture.sv
// Counts shifter steps, captures each aligned word with its direction into a FIFO.
// SHIFT_CAPTURE_PARITY_EN adds the out_par output carrying the head word's parity.
module shift_word_capture
  import shifter_pkg::*;
#(
  parameter int unsigned WORD_BITS  = WORD_BITS_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk1,
  input  logic                          Reset,
  input  logic [WORD_BITS-1:0]          q,
  input  logic                          mode,
  input  logic                          q_valid,
  output logic [WORD_BITS-1:0]          out_data,
  output logic                          out_dir,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          ovf,
  input  logic                          ovf_clr,
`ifdef SHIFT_CAPTURE_PARITY_EN
  output logic                          out_par,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned EntryW = entry_width(WORD_BITS);
  localparam int unsigned CntW   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  logic [CntW-1:0]   bit_cnt;
  logic              mode_q;
  logic              mode_chg, push, pop, full, empty, ovf_set;
  logic [EntryW-1:0] wdata, rdata;

  assign mode_chg = q_valid && (mode != mode_q);
  assign push     = q_valid && !mode_chg && (bit_cnt == CntW'(WORD_BITS - 1));
  assign pop      = out_ready && !empty;
  assign ovf_set  = push && full && !pop;

`ifdef SHIFT_CAPTURE_PARITY_EN
  assign wdata   = {mode, q, ^q};
  assign out_par = rdata[0];
`else
  assign wdata   = {mode, q};
`endif

  assign out_dir   = rdata[EntryW-1];
  assign out_data  = rdata[EntryW-2 -: WORD_BITS];
  assign out_valid = !empty;

  always_ff @(posedge clk1) begin
    if (Reset) begin
      bit_cnt <= '0;
      mode_q  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (q_valid) begin
        mode_q <= mode;
        // A direction change restarts alignment with the current shift as bit one.
        if (mode_chg) begin
          bit_cnt <= CntW'(1);
        end else if (push) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CntW'(1);
        end
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  word_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk1),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_shift_word_capture.sv
// Scoreboard bench for shift_word_capture: expected entries queued on capture, checked on pop.
module tb_shift_word_capture;
  import shifter_pkg::*;

  logic                     clk1 = 1'b0;
  logic                     Reset = 1'b1;
  logic [WORD_BITS_DEF-1:0] q = '0;
  logic                     mode = 1'b0;
  logic                     q_valid = 1'b0;
  logic [WORD_BITS_DEF-1:0] out_data;
  logic                     out_dir;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     ovf;
  logic                     ovf_clr = 1'b0;
  logic [$clog2(FIFO_DEPTH_DEF):0] level;
`ifdef SHIFT_CAPTURE_PARITY_EN
  logic                     out_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cap_entry_t sb[$];
  int         m_cnt = 0;
  logic       m_mode = 1'b0;
  logic       m_ovf = 1'b0;

  always #5 clk1 = ~clk1;

  shift_word_capture dut (
    .clk1      (clk1),
    .Reset     (Reset),
    .q         (q),
    .mode      (mode),
    .q_valid   (q_valid),
    .out_data  (out_data),
    .out_dir   (out_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
`ifdef SHIFT_CAPTURE_PARITY_EN
    .out_par   (out_par),
`endif
    .level     (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model the edge from the current inputs, advance one clock, then check status outputs.
  task automatic tick();
    logic       full_m, pop_m, chg, push_m, set_m;
    cap_entry_t e, h;
    if (Reset) begin
      sb.delete();
      m_cnt  = 0;
      m_mode = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      full_m = (sb.size() == FIFO_DEPTH_DEF);
      pop_m  = out_ready && (sb.size() != 0);
      chg    = q_valid && (mode != m_mode);
      push_m = q_valid && !chg && (m_cnt == WORD_BITS_DEF - 1);
      set_m  = 1'b0;
      if (pop_m) begin
        h = sb.pop_front();
        check("pop_data", 32'(out_data), 32'(h.data));
        check("pop_dir", 32'(out_dir), 32'(h.dir));
`ifdef SHIFT_CAPTURE_PARITY_EN
        check("pop_par", 32'(out_par), 32'(h.par));
`endif
      end
      if (push_m) begin
        e.dir  = mode;
        e.data = q;
`ifdef SHIFT_CAPTURE_PARITY_EN
        e.par  = ^q;
`endif
        if (!full_m || pop_m) sb.push_back(e);
        else set_m = 1'b1;
      end
      if (q_valid) begin
        m_mode = mode;
        if (chg) m_cnt = 1;
        else if (m_cnt == WORD_BITS_DEF - 1) m_cnt = 0;
        else m_cnt = m_cnt + 1;
      end
      if (set_m) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    @(posedge clk1);
    #1;
    check("valid", 32'(out_valid), 32'(sb.size() != 0));
    check("level", 32'(level), 32'(sb.size()));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic pulse(input logic m, input logic [WORD_BITS_DEF-1:0] d);
    mode    = m;
    q       = d;
    q_valid = 1'b1;
    tick();
    q_valid = 1'b0;
  endtask

  task automatic word(input logic m, input logic [WORD_BITS_DEF-1:0] d, input logic rdy_last);
    for (int i = 0; i < WORD_BITS_DEF - 1; i++) pulse(m, 4'($urandom_range(0, 15)));
    out_ready = rdy_last;
    pulse(m, d);
    out_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    tick();
    tick();
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_dir", 32'(out_dir), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    Reset = 1'b0;
    tick();

    // Basic capture, one-cycle latency to out_valid.
    word(MODE_TO_Q3, 4'b1011, 1'b0);
    check("cap_valid", 32'(out_valid), 32'h1);
    check("cap_data", 32'(out_data), 32'hb);
    check("cap_dir", 32'(out_dir), 32'h0);
    check("cap_level", 32'(level), 32'h1);
    drain(1);

    // Direction change realigns.
    pulse(MODE_TO_Q3, 4'h1);
    pulse(MODE_TO_Q3, 4'h2);
    pulse(MODE_TO_Q0, 4'h4);
    pulse(MODE_TO_Q0, 4'h8);
    pulse(MODE_TO_Q0, 4'b0110);
    check("realign_nopush", 32'(level), 32'h0);
    pulse(MODE_TO_Q0, 4'b0011);
    check("realign_data", 32'(out_data), 32'h3);
    check("realign_dir", 32'(out_dir), 32'h1);
    drain(1);

    // Overflow with consumer stalled.
    for (int i = 0; i < 5; i++) word(MODE_TO_Q0, 4'(i + 3), 1'b0);
    check("ovf_level", 32'(level), 32'h4);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_head", 32'(out_data), 32'h3);
    drain(4);
    check("ovf_sticky", 32'(ovf), 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'h0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) word(MODE_TO_Q0, 4'(i + 9), 1'b0);
    word(MODE_TO_Q0, 4'hd, 1'b1);
    check("full_pp_ovf", 32'(ovf), 32'h0);
    check("full_pp_level", 32'(level), 32'h4);
    drain(4);

    // Reset mid-word with words buffered.
    word(MODE_TO_Q0, 4'h5, 1'b0);
    word(MODE_TO_Q0, 4'h6, 1'b0);
    pulse(MODE_TO_Q0, 4'h1);
    pulse(MODE_TO_Q0, 4'h2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_level", 32'(level), 32'h0);
    for (int i = 0; i < 3; i++) pulse(MODE_TO_Q3, 4'(i));
    check("midrst_partial", 32'(level), 32'h0);
    pulse(MODE_TO_Q3, 4'he);
    check("midrst_full_word", 32'(level), 32'h1);
    check("midrst_data", 32'(out_data), 32'he);
    drain(1);

`ifdef SHIFT_CAPTURE_PARITY_EN
    word(MODE_TO_Q3, 4'b0111, 1'b0);
    check("par_odd", 32'(out_par), 32'h1);
    drain(1);
    word(MODE_TO_Q3, 4'b1001, 1'b0);
    check("par_even", 32'(out_par), 32'h0);
    drain(1);
`endif

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      q         = 4'($urandom_range(0, 15));
      q_valid   = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      out_ready = ($urandom_range(0, 2) == 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      Reset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    Reset     = 1'b0;
    q_valid   = 1'b0;
    ovf_clr   = 1'b0;
    drain(FIFO_DEPTH_DEF + 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
